ps2_host_tx: RTL

Host-to-device PS/2 transmitter. It sends one command byte (for example 0xED set-LEDs or 0xF4 enable) from the FPGC4 to the attached keyboard using the PS/2 host-request protocol. It sits in the MemoryUnit next to the existing PS/2 receiver and shares the ps2c/ps2d pads through open-drain drive-low enables. While busy=1, the receiver ignores the bus.

---
 rtl/ps2_host_tx.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a request-to-send,
// clocks one odd-parity frame out on the device's clock and checks the ACK bit.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | bus released, waiting for start
// INHIBIT   | host holds clock low; data pulled low on the final cycle
// REQ       | clock released, data low (start bit), waiting for first fall
// SEND      | shifting data, parity and stop bits out on device falls
// ACK       | data released, sampling the device ACK on the next rising clock
// WAIT_IDLE | waiting for clock and data both high before reporting done
// FAIL      | one-cycle error report (NACK or timeout), bus released
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 2500,
    parameter int unsigned TIMEOUT_CYCLES = 375000
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       busy,
    output logic       done,
    output logic       error,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    output logic       ps2c_low,
    output logic       ps2d_low
);
    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_REQ, S_SEND, S_ACK, S_WAIT_IDLE, S_FAIL
    } state_t;

    localparam logic [18:0] INH_LAST = 19'(INHIBIT_CYCLES - 1);
    localparam logic [18:0] INH_PRE  = 19'(INHIBIT_CYCLES - 2);
    localparam logic [18:0] TO_LIMIT = 19'(TIMEOUT_CYCLES);

    state_t      state_q, state_d;
    logic [2:0]  sync_c_q, sync_c_d;
    logic [1:0]  sync_d_q, sync_d_d;
    logic [9:0]  frame_q, frame_d;
    logic [3:0]  idx_q, idx_d;
    logic [18:0] cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic        ps2c_low_q, ps2c_low_d;
    logic        ps2d_low_q, ps2d_low_d;

    logic        c_sync, c_prev, d_sync, fall, rise, timeout;
    logic [18:0] cnt_inc;

    assign c_sync  = sync_c_q[1];
    assign c_prev  = sync_c_q[2];
    assign d_sync  = sync_d_q[1];
    assign fall    = c_prev & ~c_sync;
    assign rise    = ~c_prev & c_sync;
    assign cnt_inc = cnt_q + 19'd1;
    assign timeout = (state_q inside {S_REQ, S_SEND, S_ACK, S_WAIT_IDLE})
                     && !fall && (cnt_inc == TO_LIMIT);

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_FAIL: state_d = start ? S_INHIBIT : S_IDLE;
            S_INHIBIT:      if (cnt_q == INH_LAST) state_d = S_REQ;
            S_REQ:          if (fall) state_d = S_SEND;
            S_SEND:         if (fall && idx_q == 4'd10) state_d = S_ACK;
            S_ACK:          if (rise) state_d = d_sync ? S_FAIL : S_WAIT_IDLE;
            S_WAIT_IDLE:    if (c_sync && d_sync) state_d = S_IDLE;
            default:        state_d = S_IDLE;
        endcase
        if (timeout) state_d = S_FAIL;
    end

    // Outputs are computed from the next state so every pad enable is a flop.
    always_comb begin
        sync_c_d   = {sync_c_q[1:0], ps2c_in};
        sync_d_d   = {sync_d_q[0], ps2d_in};
        frame_d    = frame_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        ps2d_low_d = ps2d_low_q;
        case (state_q)
            S_IDLE, S_FAIL: begin
                if (start) begin
                    frame_d = {1'b1, ~^data, data};
                    idx_d   = 4'd0;
                    cnt_d   = 19'd0;
                end
            end
            S_INHIBIT: begin
                cnt_d = (cnt_q == INH_LAST) ? 19'd0 : cnt_inc;
                if (cnt_q == INH_PRE) ps2d_low_d = 1'b1;
            end
            S_REQ, S_SEND, S_ACK, S_WAIT_IDLE: begin
                cnt_d = fall ? 19'd0 : cnt_inc;
                if (fall && state_q == S_REQ) begin
                    ps2d_low_d = ~frame_q[0];
                    idx_d      = 4'd1;
                end
                if (fall && state_q == S_SEND && idx_q != 4'd10) begin
                    ps2d_low_d = ~frame_q[idx_q];
                    idx_d      = idx_q + 4'd1;
                end
            end
            default: ;
        endcase
        if (state_d inside {S_IDLE, S_FAIL, S_ACK, S_WAIT_IDLE}) ps2d_low_d = 1'b0;
        ps2c_low_d = (state_d == S_INHIBIT);
        busy_d     = !(state_d inside {S_IDLE, S_FAIL});
        done_d     = (state_q == S_WAIT_IDLE) && (state_d == S_IDLE);
        error_d    = (state_d == S_FAIL);
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            sync_c_q   <= 3'b111;
            sync_d_q   <= 2'b11;
            frame_q    <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            ps2c_low_q <= 1'b0;
            ps2d_low_q <= 1'b0;
        end else begin
            sync_c_q   <= sync_c_d;
            sync_d_q   <= sync_d_d;
            frame_q    <= frame_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            ps2c_low_q <= ps2c_low_d;
            ps2d_low_q <= ps2d_low_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;
    assign ps2c_low = ps2c_low_q;
    assign ps2d_low = ps2d_low_q;
endmodule
